// File: rtl/uart_tx_arbiter.sv
// Round-robin, burst-aware arbiter sharing one UART transmit port between NUM_REQ byte sources.
// Define UART_ARB_TAG_EN to prefix each grant with a header byte 8'hF0 | grant_id.
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 16,
    localparam int GID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      tx_valid,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_ready,
    output logic [GID_W-1:0]          grant_id,
    output logic                      busy
);

    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST + 1) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'((MAX_BURST > 0) ? MAX_BURST - 1 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HDR   = 2'd1,
        GRANT = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [GID_W-1:0]   rr_ptr, ptr_nxt;
    logic [GID_W-1:0]   gid_nxt, winner;
    logic [CNT_W-1:0]   beat_cnt, cnt_nxt;
    logic               owner_valid;

    // NOTE: every variable assigned in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        logic found;
        logic [GID_W-1:0] idx;
        winner = rr_ptr;
        found  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = GID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = rr_ptr;
        gid_nxt     = grant_id;
        cnt_nxt     = beat_cnt;
        tx_valid    = 1'b0;
        tx_data     = '0;
        req_ready   = '0;
        busy        = 1'b0;
        owner_valid = req_valid[grant_id];
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    gid_nxt = winner;
                    cnt_nxt = '0;
`ifdef UART_ARB_TAG_EN
                    state_nxt = HDR;
`else
                    state_nxt = GRANT;
`endif
                end
            end
`ifdef UART_ARB_TAG_EN
            HDR: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = DATA_W'(8'hF0) | DATA_W'(grant_id);
                if (tx_ready) state_nxt = GRANT;
            end
`endif
            GRANT: begin
                busy               = 1'b1;
                tx_valid           = owner_valid;
                req_ready[grant_id] = tx_ready;
                if (owner_valid) tx_data = req_data[grant_id*DATA_W +: DATA_W];
                if (owner_valid && tx_ready) begin
                    // Saturating so an unlimited burst never wraps back into a false limit hit.
                    if (beat_cnt != '1) cnt_nxt = beat_cnt + 1'b1;
                    if (req_last[grant_id] || (MAX_BURST != 0 && beat_cnt == LAST_BEAT)) begin
                        ptr_nxt   = GID_W'((int'(grant_id) + 1) % NUM_REQ);
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            grant_id <= '0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= ptr_nxt;
            beat_cnt <= cnt_nxt;
            grant_id <= gid_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: reset, vector table, directed corner cases and a
// randomized run against a transaction-level reference model.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 16;
`ifdef UART_ARB_TAG_EN
    localparam bit TAG = 1'b1;
`else
    localparam bit TAG = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid, req_last, req_ready;
    logic [N*DW-1:0] req_data;
    logic            tx_valid, tx_ready, busy;
    logic [DW-1:0]   tx_data;
    logic [1:0]      grant_id;

    logic [DW-1:0]   r_data [N];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        req_data = '0;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = r_data[i];
    end

    uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .tx_valid(tx_valid),
        .tx_data(tx_data), .tx_ready(tx_ready), .grant_id(grant_id), .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic tv, input logic [7:0] td,
                              input logic [3:0] rr, input logic bz, input logic [1:0] gid);
        check({tag, " tx_valid"}, tx_valid, tv);
        check({tag, " tx_data"}, tx_data, td);
        check({tag, " req_ready"}, req_ready, rr);
        check({tag, " busy"}, busy, bz);
        check({tag, " grant_id"}, grant_id, gid);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        req_valid = '0;
        req_last = '0;
        tx_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0] v;
        logic [3:0] l;
        logic       r;
        logic       tv;
        logic [7:0] td;
        logic [3:0] rr;
        logic       bz;
        logic [1:0] gid;
    } vec_t;

    // Reference model state: phase 0 = no owner, 1 = header pending, 2 = owner streaming.
    int m_phase, m_gid, m_ptr, m_cnt;

    function automatic int pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++)
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        return ptr;
    endfunction

    initial begin
        vec_t tbl [16];
        r_data[0] = 8'hA0; r_data[1] = 8'h55; r_data[2] = 8'hA2; r_data[3] = 8'hA3;

        // Reset state, with requests already pending to show outputs are forced low.
        req_valid = 4'b1111; req_last = 4'b1111; tx_ready = 1'b1;
        #3 check_outs("reset", 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;

`ifndef UART_ARB_TAG_EN
        tbl[0]  = '{4'b0010, 4'b1111, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0};
        tbl[1]  = '{4'b0010, 4'b1111, 1'b1, 1'b1, 8'h55, 4'b0010, 1'b1, 2'd1};
        tbl[2]  = '{4'b0000, 4'b1111, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd1};
        tbl[3]  = '{4'b1111, 4'b1111, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd1};
        tbl[4]  = '{4'b1111, 4'b1111, 1'b1, 1'b1, 8'hA2, 4'b0100, 1'b1, 2'd2};
        tbl[5]  = '{4'b1111, 4'b1111, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd2};
        tbl[6]  = '{4'b1111, 4'b1111, 1'b1, 1'b1, 8'hA3, 4'b1000, 1'b1, 2'd3};
        tbl[7]  = '{4'b1111, 4'b1111, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd3};
        tbl[8]  = '{4'b1111, 4'b1111, 1'b1, 1'b1, 8'hA0, 4'b0001, 1'b1, 2'd0};
        tbl[9]  = '{4'b1111, 4'b1111, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0};
        tbl[10] = '{4'b1111, 4'b1111, 1'b1, 1'b1, 8'h55, 4'b0010, 1'b1, 2'd1};
        tbl[11] = '{4'b0000, 4'b1111, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd1};
        tbl[12] = '{4'b0100, 4'b1111, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd1};
        tbl[13] = '{4'b0100, 4'b1111, 1'b0, 1'b1, 8'hA2, 4'b0000, 1'b1, 2'd2};
        tbl[14] = '{4'b0100, 4'b1111, 1'b1, 1'b1, 8'hA2, 4'b0100, 1'b1, 2'd2};
        tbl[15] = '{4'b0000, 4'b1111, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd2};
        for (int i = 0; i < 16; i++) begin
            req_valid = tbl[i].v; req_last = tbl[i].l; tx_ready = tbl[i].r;
            #1 check_outs($sformatf("vec%0d", i), tbl[i].tv, tbl[i].td, tbl[i].rr, tbl[i].bz, tbl[i].gid);
            @(negedge clk);
        end

        // Burst with stall: req2 sends 11,22,33 while req0 waits.
        reset_dut();
        req_valid = 4'b0100; req_last = 4'b0000; r_data[2] = 8'h11; tx_ready = 1'b1;
        @(negedge clk);
        req_valid = 4'b0101; req_last = 4'b0001;
        #1 check("stall b1 data", tx_data, 8'h11);
        @(negedge clk);
        r_data[2] = 8'h22; tx_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1 check("stall hold data", tx_data, 8'h22);
            check("stall ready2", req_ready[2], 1'b0);
            check("stall valid", tx_valid, 1'b1);
            @(negedge clk);
        end
        tx_ready = 1'b1;
        #1 check("stall b2 ready", req_ready, 4'b0100);
        @(negedge clk);
        r_data[2] = 8'h33; req_last[2] = 1'b1;
        #1 check("stall b3 data", tx_data, 8'h33);
        check("stall b3 owner", grant_id, 2'd2);
        @(negedge clk);
        req_valid = 4'b0001;
        #1 check("stall idle busy", busy, 1'b0);
        @(negedge clk);
        #1 check("stall next gid", grant_id, 2'd0);
        check("stall next data", tx_data, 8'hA0);
        @(negedge clk);

        // Burst limit: req3 streams 20 bytes without last; release after 16.
        reset_dut();
        req_valid = 4'b1000; req_last = 4'b0000; r_data[3] = 8'd1; tx_ready = 1'b1;
        @(negedge clk);
        req_valid = 4'b1001; req_last = 4'b0001; r_data[0] = 8'hA0;
        for (int k = 1; k <= 16; k++) begin
            #1 check($sformatf("limit byte%0d", k), tx_data, 8'(k));
            check("limit ready", req_ready, 4'b1000);
            @(negedge clk);
            r_data[3] = 8'(k + 1);
        end
        #1 check("limit release busy", busy, 1'b0);
        @(negedge clk);
        #1 check("limit next gid", grant_id, 2'd0);
        check("limit next data", tx_data, 8'hA0);
        @(negedge clk);
        req_valid = 4'b1000;
        @(negedge clk);
        #1 check("limit resume gid", grant_id, 2'd3);
        check("limit resume data", tx_data, 8'd17);
        @(negedge clk);

        // Reset mid-burst, between clock edges.
        reset_dut();
        req_valid = 4'b0010; req_last = 4'b0000; r_data[1] = 8'h31; tx_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        r_data[1] = 8'h32;
        #1 check("rstmid pre valid", tx_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1 check_outs("rstmid", 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 4'b0011; req_last = 4'b0011;
        @(negedge clk);
        #1 check("rstmid prio gid", grant_id, 2'd0);
        check("rstmid prio data", tx_data, 8'hA0);
        @(negedge clk);
`else
        // Header: req2 sends C1, UART sees F2 then C1.
        reset_dut();
        req_valid = 4'b0100; req_last = 4'b0100; r_data[2] = 8'hC1; tx_ready = 1'b1;
        @(negedge clk);
        #1 check_outs("hdr", 1'b1, 8'hF2, 4'b0000, 1'b1, 2'd2);
        @(negedge clk);
        #1 check_outs("hdr data", 1'b1, 8'hC1, 4'b0100, 1'b1, 2'd2);
        @(negedge clk);
        req_valid = 4'b0000;
        #1 check("hdr idle busy", busy, 1'b0);
        @(negedge clk);
`endif

        // Randomized run against the reference model.
        reset_dut();
        m_phase = 0; m_gid = 0; m_ptr = 0; m_cnt = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            logic       e_tv, e_bz;
            logic [7:0] e_td;
            logic [3:0] e_rr;
            int         acc;
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(2) == 0) begin
                    req_valid[i] = 1'b1;
                    r_data[i]    = 8'($urandom);
                    req_last[i]  = ($urandom_range(5) == 0);
                end
            end
            tx_ready = ($urandom_range(3) != 0);
            #1;
            e_tv = 1'b0; e_td = 8'h00; e_rr = 4'b0000; e_bz = 1'b0; acc = -1;
            if (m_phase == 1) begin
                e_tv = 1'b1; e_td = 8'hF0 | 8'(m_gid); e_bz = 1'b1;
            end else if (m_phase == 2) begin
                e_bz = 1'b1;
                e_tv = req_valid[m_gid];
                e_td = e_tv ? r_data[m_gid] : 8'h00;
                e_rr[m_gid] = tx_ready;
            end
            check_outs("rand", e_tv, e_td, e_rr, e_bz, 2'(m_gid));
            if (m_phase == 0) begin
                if (|req_valid) begin
                    m_gid = pick(req_valid, m_ptr);
                    m_cnt = 0;
                    m_phase = TAG ? 1 : 2;
                end
            end else if (m_phase == 1) begin
                if (tx_ready) m_phase = 2;
            end else if (e_tv && tx_ready) begin
                acc = m_gid;
                m_cnt++;
                if (req_last[m_gid] || m_cnt == MB) begin
                    m_ptr = (m_gid + 1) % N;
                    m_phase = 0;
                end
            end
            @(negedge clk);
            if (acc >= 0) req_valid[acc] = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares a single UART transmitter (the `tx_valid` / `in` / `tx_ready` side of the UART top) between NUM_REQ byte-stream requesters.
- Arbitration is round-robin and burst-aware. A winner keeps the UART until it signals its last byte or hits the burst limit.
- Sits between the on-chip byte sources and the UART transmit port. All requesters and the UART run in one clock domain.

Parameters:
- NUM_REQ, 4: number of requesters, 2..16.
- DATA_W, 8: byte width.
- MAX_BURST, 16: maximum transfers per grant. 0 means unlimited.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester byte valid.
- req_data  input  NUM_REQ*DATA_W  packed bytes; requester i occupies bits [i*DATA_W +: DATA_W].
- req_last  input  NUM_REQ  marks the final byte of a burst; sampled only together with req_valid.
- req_ready  output  NUM_REQ  per-requester accept.
- tx_valid  output  1  byte valid to the UART transmitter.
- tx_data  output  DATA_W  byte to the UART transmitter; connects to the UART `in` port.
- tx_ready  input  1  UART transmitter can accept a byte.
- grant_id  output  clog2(NUM_REQ)  index of the current or last owner.
- busy  output  1  a grant is active.

Behaviour:
- Reset is asynchronous active-low; the block has one clock. On reset:
  - state=IDLE, rr_ptr=0, beat_cnt=0, grant_id=0.
  - tx_valid=0, tx_data=0, req_ready=0, busy=0.
- A transfer occurs on a rising edge when tx_valid && tx_ready.
- Requesters must hold req_data/req_last stable while req_valid && !req_ready.
- IDLE state:
  - All outputs are 0 except grant_id, which holds its last value.
  - If any req_valid is set, the winner is the first set index scanning rr_ptr, rr_ptr+1, … with wrap modulo NUM_REQ.
  - On that edge: register grant_id=winner, beat_cnt=0, go to GRANT (HDR when the tag feature is enabled).
  - Arbitration latency is 1 cycle, so there is one idle bubble between grants.
- GRANT state (g=grant_id):
  - busy=1.
  - tx_valid = req_valid[g] and tx_data = req_data[g], both combinational.
  - req_ready[g] = tx_ready; all other req_ready bits are 0.
  - On each transfer, beat_cnt increments.
  - Release happens on a transfer where req_last[g]=1, or where MAX_BURST!=0 and beat_cnt==MAX_BURST-1.
  - On release: rr_ptr=(g+1) mod NUM_REQ, go to IDLE.
- If the owner drops req_valid mid-burst, the grant is held indefinitely; there is no timeout.
- tx_data is 0 whenever tx_valid=0.
- Requests from other requesters during a grant are ignored until IDLE; they are never lost, only delayed.
- Reset asserted mid-burst forces the reset values immediately, without waiting for a clock. Any partially sent burst is abandoned.
- beat_cnt is wide enough for MAX_BURST. With MAX_BURST=0 the counter saturates and is ignored.

Optional Feature:
- UART_ARB_TAG_EN defined:
  - Adds an HDR state between IDLE and GRANT.
  - In HDR: tx_valid=1, tx_data = 8'hF0 | grant_id, all req_ready=0, busy=1.
  - On transfer, go to GRANT.
  - The header byte does not count toward MAX_BURST.
  - Reset during HDR returns to IDLE.
- UART_ARB_TAG_EN undefined: no HDR state; IDLE goes directly to GRANT and the byte stream is untouched.

Test Plan:
- Single requester: only req1 valid, data 0x55, last=1, tx_ready=1 → next cycle grant_id=1, busy=1, tx_data=0x55. One transfer, then IDLE with rr_ptr=2 and busy=0.
- Round robin: all four requesters continuously valid with single-byte last=1 bursts → grant order 0,1,2,3,0,1, with one idle cycle between grants.
- Burst with stall: req2 sends 0x11,0x22,0x33 (last on 0x33) while req0 is valid. tx_ready is low for 5 cycles during 0x22 → tx_data holds 0x22 and req_ready[2]=0 for those cycles. req0 is granted only after 0x33 transfers.
- Burst limit: MAX_BURST=16, req3 sends 20 bytes with last never set, req0 also valid → release after the 16th transfer. req0 is granted next; req3 resumes later with byte 17.
- Reset mid-burst: assert rst_n=0 between clock edges during byte 2 of a req1 burst → tx_valid, req_ready and busy go to 0 immediately. After release, rr_ptr=0 and req0 has priority.
- UART_ARB_TAG_EN defined: req2 sends 0xC1 with last=1 → UART sees 0xF2 then 0xC1, and req_ready[2] stays 0 during the header.
